// File: rtl/demux5_32bits_buf.sv
// demux5_32bits_buf: buffered 1-to-5 demultiplexer for WIDTH-bit words.
// A single producer offers a word plus a one-hot destination code. The word
// is steered into one of five single-entry holding registers, and each
// register is drained by its own consumer through a valid/ack handshake.
// Words with a malformed destination code are dropped, flagged and counted.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   producer offers a word this cycle
//   in_ready   word would be taken this cycle (combinational, no in_data path)
//   in_data    word to distribute
//   in_sel     one-hot destination, bit 4 = slot 0 ... bit 0 = slot 4
//   y0..y4     slot holding registers
//   out_valid  slot holds an undelivered word, same bit order as in_sel
//   out_ack    consumer takes the slot word, same bit order as in_sel
//   sel_err    one-cycle pulse after a word with an illegal in_sel is dropped
//   drop_cnt   saturating count of dropped words
module demux5_32bits_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [4:0]       in_sel,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [4:0]       out_valid,
  input  logic [4:0]       out_ack,
  output logic             sel_err,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned NSLOT = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // valid_q keeps the in_sel bit order; y_q is indexed by slot number
  logic [NSLOT-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] y_q [NSLOT];
  logic [WIDTH-1:0] y_d [NSLOT];
  logic             sel_err_q, sel_err_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             sel_legal;
  logic [NSLOT-1:0] slot_free;
  logic             accept;
  logic             drop;
  logic [NSLOT-1:0] wr_mask;
  logic [NSLOT-1:0] wr_slot;

  // Destination decode and acceptance; a slot being acked this cycle counts
  // as free so a single slot can stream one word per cycle
  always_comb begin
    sel_legal = (in_sel != '0) && ((in_sel & (in_sel - 5'd1)) == '0);
    slot_free = ~valid_q | out_ack;
    in_ready  = !sel_legal || ((in_sel & slot_free) != '0);
    accept    = in_valid && in_ready;
    drop      = accept && !sel_legal;
    wr_mask   = (accept && sel_legal) ? in_sel : '0;
    // reorder to slot numbering: slot k sits at in_sel bit (4-k)
    wr_slot   = {wr_mask[0], wr_mask[1], wr_mask[2], wr_mask[3], wr_mask[4]};
  end

  // Next-state: ack clears, a same-cycle write wins and keeps the slot valid
  always_comb begin
    valid_d = (valid_q & ~out_ack) | wr_mask;
    for (int k = 0; k < NSLOT; k++) begin
      y_d[k] = wr_slot[k] ? in_data : y_q[k];
    end
    sel_err_d  = drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != CNT_MAX)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= '0;
      sel_err_q  <= 1'b0;
      drop_cnt_q <= '0;
      for (int k = 0; k < NSLOT; k++) begin
        y_q[k] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      sel_err_q  <= sel_err_d;
      drop_cnt_q <= drop_cnt_d;
      for (int k = 0; k < NSLOT; k++) begin
        y_q[k] <= y_d[k];
      end
    end
  end

  assign y0        = y_q[0];
  assign y1        = y_q[1];
  assign y2        = y_q[2];
  assign y3        = y_q[3];
  assign y4        = y_q[4];
  assign out_valid = valid_q;
  assign sel_err   = sel_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux5_32bits_buf.sv
// Testbench for demux5_32bits_buf: directed vector table, counter saturation,
// asynchronous mid-cycle reset and randomized traffic against a slot model.
module tb_demux5_32bits_buf;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [4:0]       in_sel;
  logic [WIDTH-1:0] y0, y1, y2, y3, y4;
  logic [4:0]       out_valid;
  logic [4:0]       out_ack;
  logic             sel_err;
  logic [CNT_W-1:0] drop_cnt;

  demux5_32bits_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .y4        (y4),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .sel_err   (sel_err),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one entry per slot, slot numbers 0..4
  logic [31:0] m_y [5];
  logic        m_v [5];
  logic        m_err;
  int          m_cnt;

  typedef struct {
    logic        v;
    logic [4:0]  sel;
    logic [31:0] d;
    logic [4:0]  ack;
    logic        exp_ready;
    logic [4:0]  exp_valid;
    logic        exp_err;
    logic [7:0]  exp_cnt;
    int          yslot;
    logic [31:0] exp_y;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_y(input int k);
    case (k)
      0: return y0;
      1: return y1;
      2: return y2;
      3: return y3;
      default: return y4;
    endcase
  endfunction

  function automatic int sel_slot(input logic [4:0] sel);
    for (int k = 0; k < 5; k++) if (sel[4-k]) return k;
    return -1;
  endfunction

  function automatic logic mdl_ready(input logic [4:0] sel, input logic [4:0] ack);
    int k;
    if ($countones(sel) != 1) return 1'b1;
    k = sel_slot(sel);
    return !m_v[k] || ack[4-k];
  endfunction

  function automatic logic [4:0] mdl_valid();
    logic [4:0] r;
    for (int k = 0; k < 5; k++) r[4-k] = m_v[k];
    return r;
  endfunction

  task automatic mdl_reset();
    for (int k = 0; k < 5; k++) begin
      m_y[k] = '0;
      m_v[k] = 1'b0;
    end
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic mdl_edge(input logic v, input logic [4:0] sel, input logic [31:0] d,
                          input logic [4:0] ack);
    logic legal, acc;
    legal = ($countones(sel) == 1);
    acc   = v && mdl_ready(sel, ack);
    for (int k = 0; k < 5; k++) if (m_v[k] && ack[4-k]) m_v[k] = 1'b0;
    if (acc && legal) begin
      m_y[sel_slot(sel)] = d;
      m_v[sel_slot(sel)] = 1'b1;
    end
    m_err = acc && !legal;
    if (m_err && m_cnt < 255) m_cnt++;
  endtask

  task automatic chk_all();
    chk("out_valid", 32'(out_valid), 32'(mdl_valid()));
    chk("sel_err", 32'(sel_err), 32'(m_err));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
    for (int k = 0; k < 5; k++) chk($sformatf("y%0d", k), dut_y(k), m_y[k]);
  endtask

  // Drive one cycle of inputs, check in_ready before the edge, outputs after
  task automatic step(input logic v, input logic [4:0] sel, input logic [31:0] d,
                      input logic [4:0] ack, output logic rdy);
    in_valid = v;
    in_sel   = sel;
    in_data  = d;
    out_ack  = ack;
    #1;
    rdy = in_ready;
    chk("in_ready", 32'(rdy), 32'(mdl_ready(sel, ack)));
    @(posedge clk);
    mdl_edge(v, sel, d, ack);
    #1;
    chk_all();
  endtask

  initial begin
    logic rdy;
    logic [4:0] rsel;

    tbl[0]  = '{1'b1, 5'b00100, 32'hDEADBEEF, 5'b00000, 1'b1, 5'b00100, 1'b0, 8'd0, 2, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 5'b10000, 32'hA0A0A0A0, 5'b00000, 1'b1, 5'b10100, 1'b0, 8'd0, 0, 32'hA0A0A0A0};
    tbl[2]  = '{1'b1, 5'b10000, 32'hBBBB0000, 5'b00000, 1'b0, 5'b10100, 1'b0, 8'd0, 0, 32'hA0A0A0A0};
    tbl[3]  = '{1'b1, 5'b10000, 32'hCCCC0001, 5'b10000, 1'b1, 5'b10100, 1'b0, 8'd0, 0, 32'hCCCC0001};
    tbl[4]  = '{1'b1, 5'b00001, 32'h00000001, 5'b00001, 1'b1, 5'b10101, 1'b0, 8'd0, 4, 32'h00000001};
    tbl[5]  = '{1'b1, 5'b00001, 32'h00000002, 5'b00001, 1'b1, 5'b10101, 1'b0, 8'd0, 4, 32'h00000002};
    tbl[6]  = '{1'b1, 5'b00001, 32'h00000003, 5'b00001, 1'b1, 5'b10101, 1'b0, 8'd0, 4, 32'h00000003};
    tbl[7]  = '{1'b1, 5'b00000, 32'h00000055, 5'b00000, 1'b1, 5'b10101, 1'b1, 8'd1, 0, 32'hCCCC0001};
    tbl[8]  = '{1'b1, 5'b11000, 32'h00000066, 5'b00000, 1'b1, 5'b10101, 1'b1, 8'd2, 1, 32'h00000000};
    tbl[9]  = '{1'b0, 5'b00100, 32'h00000077, 5'b00100, 1'b1, 5'b10001, 1'b0, 8'd2, 2, 32'hDEADBEEF};
    tbl[10] = '{1'b1, 5'b01000, 32'h12345678, 5'b10001, 1'b1, 5'b01000, 1'b0, 8'd2, 1, 32'h12345678};
    tbl[11] = '{1'b0, 5'b11111, 32'h00000088, 5'b00000, 1'b1, 5'b01000, 1'b0, 8'd2, 4, 32'h00000003};

    // Reset
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_sel   = '0;
    in_data  = '0;
    out_ack  = '0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    in_sel = 5'b00100;
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ack, rdy);
      chk($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_err", i), 32'(sel_err), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_cnt", i), 32'(drop_cnt), 32'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_y%0d", i, tbl[i].yslot), dut_y(tbl[i].yslot), tbl[i].exp_y);
    end

    // 260 back-to-back illegal words: sel_err stays high, counter saturates
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 5'b00011, $urandom, 5'b00000, rdy);
      chk("sat_err_high", 32'(sel_err), 32'd1);
    end
    chk("sat_cnt", 32'(drop_cnt), 32'hFF);
    chk("sat_valid", 32'(out_valid), 32'b01000);

    // Fill slots 1 and 3, then reset asynchronously in the middle of a cycle
    step(1'b1, 5'b01000, 32'h11111111, 5'b00000, rdy);
    step(1'b1, 5'b00010, 32'h33333333, 5'b00000, rdy);
    chk("pre_rst_valid", 32'(out_valid), 32'b01010);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    mdl_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_y1", y1, 32'd0);
    chk("rst_y3", y3, 32'd0);
    chk("rst_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_err", 32'(sel_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    in_sel = 5'b01000;
    #1;
    chk("rst_ready_legal", 32'(in_ready), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) rsel = 5'b00001 << $urandom_range(0, 4);
      else rsel = 5'($urandom);
      step($urandom_range(0, 3) != 0, rsel, $urandom, 5'($urandom), rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
